// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the multicycle control FSM
// (master) and the iterative multiply/divide unit (slave).
//
// Handshake: start is a one-cycle request, sampled only while the unit is
// idle (busy=0 and done=0); requests seen at any other time are dropped.
// There is no ready signal: after issuing start the master stalls while
// busy is high and takes hi_out/lo_out/div_zero in the cycle done pulses.
// state_dbg mirrors the unit's FSM state for observation only.
interface mult_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic             unsigned_op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [1:0]       state_dbg;

  modport master (
    output start, op, unsigned_op, a_in, b_in,
    input  hi_out, lo_out, busy, done, div_zero, state_dbg
  );

  modport slave (
    input  start, op, unsigned_op, a_in, b_in,
    output hi_out, lo_out, busy, done, div_zero, state_dbg
  );
endinterface

// File: rtl/mult_div.sv
// mult_div: iterative multiply/divide unit, one bit per cycle.
// MULT uses radix-2 Booth on {acc, q, q_m1}; DIV uses restoring division on
// the operand magnitudes with sign correction in FIX.
// Optional macro MULT_DIV_UNSIGNED_EN: when defined, unsigned_op is captured
// with start and selects MULTU/DIVU; when undefined every operation is signed.
module mult_div #(
  parameter int WIDTH = 32
) (
  input logic       clock,
  input logic       reset,
  mult_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count;
  logic             op_div;
  logic [WIDTH:0]   acc;       // one guard bit so Booth never overflows
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_m1;
  logic             a_neg;
  logic             quo_neg;
  logic             dz_pend;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             div_zero_q;
  logic             sgn_in, is_signed;

`ifdef MULT_DIV_UNSIGNED_EN
  logic is_signed_q;
  assign sgn_in    = ~bus.unsigned_op;
  assign is_signed = is_signed_q;

  // Signedness of the running operation, latched when start is accepted.
  always_ff @(posedge clock) begin
    if (reset)                          is_signed_q <= 1'b1;
    else if (state == IDLE && bus.start) is_signed_q <= sgn_in;
  end
`else
  logic unused_unsigned_op;
  assign unused_unsigned_op = bus.unsigned_op;
  assign sgn_in    = 1'b1;
  assign is_signed = 1'b1;
`endif

  // Capture-time operand signs and magnitudes for the divider.
  logic             a_in_neg, b_in_neg, dz_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_in_neg = sgn_in & bus.a_in[WIDTH-1];
  assign b_in_neg = sgn_in & bus.b_in[WIDTH-1];
  assign a_mag    = a_in_neg ? -bus.a_in : bus.a_in;
  assign b_mag    = b_in_neg ? -bus.b_in : bus.b_in;
  assign dz_in    = bus.op && (bus.b_in == '0);

  // One multiply step: Booth add/subtract (or plain add for MULTU), then shift right.
  logic [WIDTH:0]   m_ext, mul_sum, mul_acc_n;
  logic [WIDTH-1:0] mul_q_n;
  logic             shift_in;
  assign m_ext = {is_signed & m[WIDTH-1], m};
  always_comb begin
    mul_sum = acc;
    if (is_signed) begin
      if (q[0] && !q_m1)      mul_sum = acc - m_ext;
      else if (!q[0] && q_m1) mul_sum = acc + m_ext;
    end else if (q[0]) begin
      mul_sum = acc + m_ext;
    end
  end
  assign shift_in  = is_signed ? mul_sum[WIDTH] : 1'b0;
  assign mul_acc_n = {shift_in, mul_sum[WIDTH:1]};
  assign mul_q_n   = {mul_sum[0], q[WIDTH-1:1]};

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   div_shift, div_acc_n;
  logic             div_ge;
  logic [WIDTH-1:0] div_q_n;
  assign div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, m};
  assign div_acc_n = div_ge ? div_shift - {1'b0, m} : div_shift;
  assign div_q_n   = {q[WIDTH-2:0], div_ge};

  // Final result: divide signs applied (truncate toward zero), multiply passes through.
  logic [WIDTH-1:0] fix_hi, fix_lo;
  assign fix_hi = (op_div && a_neg)   ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign fix_lo = (op_div && quo_neg) ? -q : q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; divide by zero skips CALC so done still lands two cycles after start.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = dz_in ? FIX : CALC;
      CALC:    if (count == CW'(1)) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture in IDLE, iterate in CALC, publish results on FIX->DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      op_div     <= 1'b0;
      acc        <= '0;
      q          <= '0;
      m          <= '0;
      q_m1       <= 1'b0;
      a_neg      <= 1'b0;
      quo_neg    <= 1'b0;
      dz_pend    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          count      <= CW'(WIDTH);
          op_div     <= bus.op;
          acc        <= '0;
          q_m1       <= 1'b0;
          div_zero_q <= 1'b0;
          dz_pend    <= dz_in;
          if (bus.op) begin
            q       <= a_mag;
            m       <= b_mag;
            a_neg   <= a_in_neg;
            quo_neg <= a_in_neg ^ b_in_neg;
          end else begin
            q       <= bus.b_in;
            m       <= bus.a_in;
            a_neg   <= 1'b0;
            quo_neg <= 1'b0;
          end
        end
        CALC: begin
          count <= count - CW'(1);
          if (op_div) begin
            acc <= div_acc_n;
            q   <= div_q_n;
          end else begin
            acc  <= mul_acc_n;
            q    <= mul_q_n;
            q_m1 <= q[0];
          end
        end
        FIX: begin
          if (dz_pend) begin
            div_zero_q <= 1'b1;
          end else begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.busy      = (state == CALC) || (state == FIX);
  assign bus.done      = (state == DONE);
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: randomized and directed stimulus for mult_div, checked every
// cycle against a transaction-level model (plain 64-bit arithmetic plus a
// busy countdown), with literal expectations for the hand-worked cases.
`timescale 1ns/1ps
module tb_mult_div;
  localparam int W = 32;

  // Clock and reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mult_div_if #(.WIDTH(W)) bus();
  mult_div #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: what HI/LO must hold for one operation.
  function automatic void model_calc(input logic op, input logic uop,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] hi, output logic [W-1:0] lo,
                                     output bit dz);
    bit u;
    longint sa, sb, r64, q64;
`ifdef MULT_DIV_UNSIGNED_EN
    u = uop;
`else
    u = uop & 1'b0;
`endif
    sa = u ? {32'b0, a} : {{32{a[W-1]}}, a};
    sb = u ? {32'b0, b} : {{32{b[W-1]}}, b};
    hi = '0;
    lo = '0;
    dz = 1'b0;
    if (!op) begin
      r64 = sa * sb;
      hi  = r64[63:32];
      lo  = r64[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      q64 = sa / sb;
      r64 = sa % sb;
      lo  = q64[31:0];
      hi  = r64[31:0];
    end
  endfunction

  // Cycle-level model: busy for W+1 cycles (1 for divide by zero), then one done cycle.
  int             busy_left = 0;
  bit             in_done   = 1'b0;
  logic [W-1:0]   m_hi = '0, m_lo = '0, p_hi, p_lo;
  bit             m_dz = 1'b0, p_dz;

  always @(posedge clock) begin
    if (reset) begin
      busy_left = 0;
      in_done   = 1'b0;
      m_hi      = '0;
      m_lo      = '0;
      m_dz      = 1'b0;
    end else if (in_done) begin
      in_done = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        in_done = 1'b1;
        m_dz    = p_dz;
        if (!p_dz) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end else if (bus.start) begin
      model_calc(bus.op, bus.unsigned_op, bus.a_in, bus.b_in, p_hi, p_lo, p_dz);
      m_dz      = 1'b0;
      busy_left = p_dz ? 1 : W + 1;
    end
  end

  // Scoreboard compare on the falling edge, every cycle after reset has been seen.
  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(busy_left > 0));
      check("done", 64'(bus.done), 64'(in_done));
      check("div_zero", 64'(bus.div_zero), 64'(m_dz));
      check("hi_out", 64'(bus.hi_out), 64'(m_hi));
      check("lo_out", 64'(bus.lo_out), 64'(m_lo));
    end
  end

  // Driver: issue one start, optionally re-pulse/junk start while running, wait for done.
  task automatic run_op(input logic op, input logic uop, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int repulse_at, input bit junk, output int lat, output int busy_n);
    @(negedge clock);
    bus.start = 1'b1; bus.op = op; bus.unsigned_op = uop; bus.a_in = a; bus.b_in = b;
    lat = 0;
    busy_n = 0;
    do begin
      @(negedge clock);
      lat++;
      bus.start = 1'b0;
      if (lat == repulse_at) begin
        bus.start = 1'b1; bus.op = ~op; bus.a_in = $urandom; bus.b_in = '0;
      end else if (junk && $urandom_range(0, 5) == 0) begin
        bus.start = 1'b1; bus.op = 1'($urandom_range(0, 1));
        bus.a_in = $urandom; bus.b_in = $urandom;
      end
      if (bus.busy) busy_n++;
    end while (!bus.done && lat < 100);
    check("done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic idle(input int n, output int dn);
    dn = 0;
    repeat (n) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (bus.done) dn++;
    end
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, busy_n, dn;
    logic op_r, uop_r;
    logic [W-1:0] a_r, b_r;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.unsigned_op = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi_out), 64'd0);
    check("rst_lo", 64'(bus.lo_out), 64'd0);
    check("rst_dz", 64'(bus.div_zero), 64'd0);
    reset = 1'b0;

    // MULT 7 x -3
    run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0, lat, busy_n);
    check("t1_lat", 64'(lat), 64'd34);
    check("t1_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
    check("t1_lo", 64'(bus.lo_out), 64'hFFFF_FFEB);
    check("t1_dz", 64'(bus.div_zero), 64'd0);

    // DIV -7 / 2
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, lat, busy_n);
    check("t2_busy_cycles", 64'(busy_n), 64'd33);
    check("t2_lo", 64'(bus.lo_out), 64'hFFFF_FFFD);
    check("t2_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);

    // DIV overflow case, then divide by zero keeps HI/LO
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, lat, busy_n);
    check("t3_lo", 64'(bus.lo_out), 64'h8000_0000);
    check("t3_hi", 64'(bus.hi_out), 64'd0);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 0, 1'b0, lat, busy_n);
    check("t3z_lat", 64'(lat), 64'd2);
    check("t3z_dz", 64'(bus.div_zero), 64'd1);
    check("t3z_hi", 64'(bus.hi_out), 64'd0);
    check("t3z_lo", 64'(bus.lo_out), 64'h8000_0000);

    // MULT with start re-pulsed mid-run and operands changed
    run_op(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 10, 1'b0, lat, busy_n);
    check("t4_hi", 64'(bus.hi_out), 64'd1);
    check("t4_lo", 64'(bus.lo_out), 64'd0);
    idle(40, dn);
    check("t4_single_done", 64'(dn), 64'd0);

    // Reset mid-operation, then DIV 100 / 7
    @(negedge clock);
    bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 32'h1234_5678; bus.b_in = 32'h9ABC_DEF0;
    repeat (15) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_done", 64'(bus.done), 64'd0);
    check("t5_hi", 64'(bus.hi_out), 64'd0);
    check("t5_lo", 64'(bus.lo_out), 64'd0);
    reset = 1'b0;
    idle(40, dn);
    check("t5_no_done", 64'(dn), 64'd0);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 0, 1'b0, lat, busy_n);
    check("t5_lo_div", 64'(bus.lo_out), 64'd14);
    check("t5_hi_div", 64'(bus.hi_out), 64'd2);

    // MULT 0xFFFFFFFF x 2 with unsigned_op set
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, lat, busy_n);
`ifdef MULT_DIV_UNSIGNED_EN
    check("t6_hi", 64'(bus.hi_out), 64'd1);
`else
    check("t6_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
`endif
    check("t6_lo", 64'(bus.lo_out), 64'hFFFF_FFFE);

    // Randomized operations with stray start pulses while running
    for (int i = 0; i < 60; i++) begin
      op_r  = 1'($urandom_range(0, 1));
      uop_r = 1'($urandom_range(0, 1));
      a_r   = pick_val();
      b_r   = pick_val();
      run_op(op_r, uop_r, a_r, b_r, 0, 1'b1, lat, busy_n);
      check("rand_lat", 64'(lat), (op_r && b_r == '0) ? 64'd2 : 64'(W + 2));
      idle($urandom_range(1, 3), dn);
    end

    idle(2, dn);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
